// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// State encoding, parity types, legal prescale values, frame sizes.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    localparam int unsigned DATA_BITS = 8;
    // Wide enough for the frame-bit index (start + 8 data + parity + stop).
    localparam int unsigned BIT_CNT_W = 4;

    function automatic logic presc_legal(input int unsigned p);
        return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and frame-bit counter for the UART receiver.
// Ports: clk, rst, enable, load1, prescale in; finish, bit_cnt out.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load1,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  finish,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    assign finish  = enable && (edge_cnt_q == prescale - PRESCALE_W'(1));
    assign bit_cnt = bit_cnt_q;

    // bit_cnt is the frame-bit index: 0 during START, 1..8 during DATA.
    always_comb begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (load1) begin
            // The start-detect cycle already counts as edge 0.
            edge_cnt_d = PRESCALE_W'(1);
        end else if (enable) begin
            if (finish) begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
                bit_cnt_d  = bit_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detect, bit timing, sampler/deserializer
// sequencing, parity/stop checks and one-cycle status pulses.
// Ports: clk, rst, rx_in, prescale, par_en, par_typ, sampled_bit in;
// samp_en, deser_en, finish, data_valid, par_err, stp_err, strt_glitch, busy out.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_bit,
    output logic                  samp_en,
    output logic                  deser_en,
    output logic                  finish,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    rx_state_e state_q, state_d;

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  acc_q, acc_d;
    logic                  par_bad_q, par_bad_d;
    logic                  dv_q, dv_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  glitch_q, glitch_d;

    logic                  load1;
    logic                  cnt_en;
    logic                  fin;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  exp_par;

    assign cnt_en = (state_q != ST_IDLE);

    uart_rx_edge_bit_counter #(
        .PRESCALE_W(PRESCALE_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .enable  (cnt_en),
        .load1   (load1),
        .prescale(presc_q),
        .finish  (fin),
        .bit_cnt (bit_cnt)
    );

    assign exp_par = (par_typ_q == PAR_ODD) ? ~acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        acc_d     = acc_q;
        par_bad_d = par_bad_q;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        glitch_d  = 1'b0;
        load1     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_in) begin
                    state_d   = ST_START;
                    load1     = 1'b1;
                    // Unsupported ratios fall back to 8.
                    presc_d   = presc_legal(32'(prescale))
                              ? prescale : PRESCALE_W'(PRESC_8);
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    acc_d     = 1'b0;
                    par_bad_d = 1'b0;
                end
            end
            ST_START: begin
                if (fin) begin
                    if (!sampled_bit) begin
                        state_d = ST_DATA;
                        acc_d   = 1'b0;
                    end else begin
                        state_d  = ST_IDLE;
                        glitch_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fin) begin
                    acc_d = acc_q ^ sampled_bit;
                    if (bit_cnt == BIT_CNT_W'(DATA_BITS)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (fin) begin
                    state_d = ST_STOP;
                    if (sampled_bit != exp_par) begin
                        par_bad_d = 1'b1;
                        perr_d    = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (fin) begin
                    state_d = ST_IDLE;
                    if (!sampled_bit) begin
                        serr_d = 1'b1;
                    end else if (!par_bad_q) begin
                        dv_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= PRESCALE_W'(PRESC_8);
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            acc_q     <= 1'b0;
            par_bad_q <= 1'b0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
            glitch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            acc_q     <= acc_d;
            par_bad_q <= par_bad_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
            glitch_q  <= glitch_d;
        end
    end

    assign samp_en     = cnt_en;
    assign busy        = cnt_en;
    assign deser_en    = (state_q == ST_DATA);
    assign finish      = fin;
    assign data_valid  = dv_q;
    assign par_err     = perr_q;
    assign stp_err     = serr_q;
    assign strt_glitch = glitch_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for uart_rx_fsm.
// Line model drives rx_in; sampled_bit mirrors the line; small deserializer model.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       sampled_bit;
    logic       samp_en, deser_en, finish, data_valid;
    logic       par_err, stp_err, strt_glitch, busy;

    uart_rx_fsm #(.PRESCALE_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .sampled_bit(sampled_bit),
        .samp_en    (samp_en),
        .deser_en   (deser_en),
        .finish     (finish),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .strt_glitch(strt_glitch),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Bits are held for a whole bit period, so the line value is a valid sample.
    assign sampled_bit = rx_in;

    int         cyc = 0;
    logic [7:0] p_data = 8'h00;
    int n_fin = 0, n_dv = 0, n_stp = 0, n_par = 0, n_gl = 0;
    int n_busy = 0, n_de = 0, n_both = 0;
    int dv_cyc = -1, dv_prev = -1, stp_cyc = -1, par_cyc = -1;
    int gl_cyc = -1, fin_first = -1, fin_last = -1;
    int checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (deser_en && finish) p_data <= {sampled_bit, p_data[7:1]};
    end

    always @(negedge clk) begin
        if (finish) begin
            n_fin    <= n_fin + 1;
            fin_last <= cyc;
            if (fin_first < 0) fin_first <= cyc;
        end
        if (data_valid) begin
            n_dv    <= n_dv + 1;
            dv_prev <= dv_cyc;
            dv_cyc  <= cyc;
        end
        if (stp_err) begin
            n_stp   <= n_stp + 1;
            stp_cyc <= cyc;
        end
        if (par_err) begin
            n_par   <= n_par + 1;
            par_cyc <= cyc;
        end
        if (strt_glitch) begin
            n_gl   <= n_gl + 1;
            gl_cyc <= cyc;
        end
        if (busy) n_busy <= n_busy + 1;
        if (deser_en) n_de <= n_de + 1;
        if (data_valid && stp_err) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int p);
        rx_in = v;
        repeat (p) step();
    endtask

    task automatic send_frame(input logic [7:0] b, input int p,
                              input logic has_par, input logic pbit,
                              input logic sbit, output int t);
        t = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(b[i], p);
        if (has_par) drive_bit(pbit, p);
        drive_bit(sbit, p);
        rx_in = 1'b1;
    endtask

    int t, t2;
    int b_fin, b_dv, b_err, b_busy, b_de, b_par, b_stp, b_gl;

    task automatic snap();
        b_fin  = n_fin;
        b_dv   = n_dv;
        b_err  = n_stp + n_par + n_gl;
        b_busy = n_busy;
        b_de   = n_de;
        b_par  = n_par;
        b_stp  = n_stp;
        b_gl   = n_gl;
    endtask

    function automatic logic [7:0] outs();
        return {samp_en, deser_en, finish, data_valid,
                par_err, stp_err, strt_glitch, busy};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", int'(outs()), 0);
        step();

        // P=8, no parity, 0xA5
        snap();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, t);
        repeat (3) step();
        chk("a5_fin_cnt", n_fin - b_fin, 10);
        chk("a5_fin_first", fin_first, t + 7);
        chk("a5_fin_last", fin_last, t + 79);
        chk("a5_dv_cnt", n_dv - b_dv, 1);
        chk("a5_dv_cyc", dv_cyc, t + 80);
        chk("a5_pdata", int'(p_data), 'hA5);
        chk("a5_errs", n_stp + n_par + n_gl - b_err, 0);
        chk("a5_busy_cyc", n_busy - b_busy, 79);
        chk("a5_deser_cyc", n_de - b_de, 64);
        chk("a5_busy_after", int'(busy), 0);

        // P=16, even parity, 0x3C, correct parity bit 0
        prescale = 6'd16;
        par_en   = 1'b1;
        par_typ  = 1'b0;
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, t);
        repeat (3) step();
        chk("3c_fin_cnt", n_fin - b_fin, 11);
        chk("3c_dv_cnt", n_dv - b_dv, 1);
        chk("3c_dv_cyc", dv_cyc, t + 176);
        chk("3c_perr_cnt", n_par - b_par, 0);
        chk("3c_pdata", int'(p_data), 'h3C);

        // same byte, wrong parity bit 1
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, t);
        repeat (3) step();
        chk("3cbad_perr_cnt", n_par - b_par, 1);
        chk("3cbad_perr_cyc", par_cyc, t + 160);
        chk("3cbad_dv_cnt", n_dv - b_dv, 0);
        chk("3cbad_stp_cnt", n_stp - b_stp, 0);

        // start glitch, P=16
        snap();
        t = cyc;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 20);
        chk("gl_cnt", n_gl - b_gl, 1);
        chk("gl_cyc", gl_cyc, t + 16);
        chk("gl_deser_cyc", n_de - b_de, 0);
        chk("gl_fin_cnt", n_fin - b_fin, 1);
        chk("gl_busy_cyc", n_busy - b_busy, 15);
        chk("gl_busy_after", int'(busy), 0);

        // stop bit error, P=8, no parity
        prescale = 6'd8;
        par_en   = 1'b0;
        snap();
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, t);
        repeat (3) step();
        chk("stp_cnt", n_stp - b_stp, 1);
        chk("stp_cyc", stp_cyc, t + 80);
        chk("stp_dv_cnt", n_dv - b_dv, 0);
        chk("stp_both", n_both, 0);
        chk("stp_busy_after", int'(busy), 0);

        // illegal prescale falls back to 8
        prescale = 6'd5;
        snap();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, t);
        repeat (3) step();
        chk("p5_dv_cyc", dv_cyc, t + 80);
        chk("p5_pdata", int'(p_data), 'h81);

        // P=32, odd parity, back-to-back 0x00 then 0xFF
        prescale = 6'd32;
        par_en   = 1'b1;
        par_typ  = 1'b1;
        snap();
        send_frame(8'h00, 32, 1'b1, 1'b1, 1'b1, t);
        send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b1, t2);
        repeat (3) step();
        chk("b2b_dv_cnt", n_dv - b_dv, 2);
        chk("b2b_dv_gap", dv_cyc - dv_prev, 352);
        chk("b2b_dv_cyc", dv_cyc, t + 704);
        chk("b2b_pdata", int'(p_data), 'hFF);
        chk("b2b_errs", n_stp + n_par + n_gl - b_err, 0);

        // reset during DATA bit 4, then a clean 0x5A frame
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        snap();
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
        drive_bit(1'b0, 3);
        rst = 1'b1;
        step();
        rst   = 1'b0;
        rx_in = 1'b1;
        @(negedge clk);
        chk("rst_outs", int'(outs()), 0);
        repeat (20) step();
        chk("rst_dv_cnt", n_dv - b_dv, 0);
        chk("rst_errs", n_stp + n_par + n_gl - b_err, 0);
        snap();
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, t);
        repeat (3) step();
        chk("post_dv_cyc", dv_cyc, t + 80);
        chk("post_dv_cnt", n_dv - b_dv, 1);
        chk("post_pdata", int'(p_data), 'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
